nms_frame_ctrl: RTL

- Frame-level sequencer in front of the NMS_top non-maximum-suppression stage.
- Accepts the raster score stream from the FAST score stage and generates the coordinates, end-of-line and clock-enable strobes that NMS_top needs.
- At end of frame, injects zero-score flush pixels so the last image rows clear the NMS line buffers.
- Collects surviving corners into a small output FIFO; stalls the upstream stream (and freezes NMS via ce) when that FIFO cannot absorb in-flight results.

---
 rtl/nms_pkg.sv | 31 +++
 rtl/nms_corner_fifo.sv | 62 ++++++
 rtl/nms_frame_ctrl.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/nms_pkg.sv
// nms_pkg
// Shared definitions for the NMS frame sequencer slice: score and coordinate
// widths, the frame FSM state type, the packed corner record stored in the
// output FIFO, and the helper that sizes the end-of-frame flush.
package nms_pkg;

  localparam int SCORE_W = 13;
  localparam int COORD_W = 10;

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    FLUSH,
    DRAIN,
    DONE
  } state_t;

  // x sits in the upper half so the packed record matches {x, y}.
  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
  } corner_t;

  // Number of zero pixels to feed after the last real pixel so the window
  // centred on the bottom-right pixel is complete: half a window of full
  // rows plus half a window of columns.
  function automatic int flush_pix(input int col_num, input int nms_size);
    return col_num * (nms_size / 2) + nms_size / 2;
  endfunction

endpackage

// File: rtl/nms_corner_fifo.sv
// nms_corner_fifo
// Synchronous FIFO holding surviving corners until downstream pops them.
// Ports:
//   clk, rst       clock, synchronous active-low reset (empties the FIFO)
//   push, din      write request and data; dropped when full unless popping
//   pop            read request; ignored when empty
//   head           oldest entry (valid while !empty)
//   full, empty    occupancy flags
//   count          current number of entries
module nms_corner_fifo #(
  parameter int WIDTH = 20,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // A push into a full FIFO is still accepted when the head leaves in the
  // same cycle; the freed slot is exactly the one being written.
  assign empty   = (count == '0);
  assign full    = (count == DEPTH_C);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/nms_frame_ctrl.sv
// nms_frame_ctrl
// Frame-level sequencer in front of NMS_top. Turns the raster score stream
// into coordinates/eol/ce strobes, appends zero flush pixels and ce-only
// drain cycles at end of frame, and collects surviving corners in a FIFO.
// Ports:
//   clk, rst                      clock, synchronous active-low reset
//   frame_start                   arms a new frame (pulse)
//   pix_vld/pix_score/pix_corner  upstream stream, pix_rdy back-pressure
//   nms_*                         strobes to / results from NMS_top
//   crn_vld/crn_x/crn_y/crn_rdy   corner output FIFO interface
//   busy, frame_done, corner_cnt  frame status
//   err                           sticky: restart while busy or FIFO overflow
module nms_frame_ctrl
  import nms_pkg::*;
#(
  parameter int COL_NUM     = 640,
  parameter int ROW_NUM     = 480,
  parameter int NMS_SIZE    = 3,
  parameter int NMS_LAT     = 3,
  parameter int OFIFO_DEPTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               frame_start,
  input  logic               pix_vld,
  input  logic [SCORE_W-1:0] pix_score,
  input  logic               pix_corner,
  output logic               pix_rdy,
  output logic               nms_ce,
  output logic [COORD_W-1:0] nms_x,
  output logic [COORD_W-1:0] nms_y,
  output logic               nms_iscorner,
  output logic [SCORE_W-1:0] nms_score,
  output logic               nms_eol,
  output logic               nms_xy_vld,
  input  logic               nms_corner_out,
  input  logic [COORD_W-1:0] nms_x_out,
  input  logic [COORD_W-1:0] nms_y_out,
  output logic               crn_vld,
  output logic [COORD_W-1:0] crn_x,
  output logic [COORD_W-1:0] crn_y,
  input  logic               crn_rdy,
  output logic               busy,
  output logic               frame_done,
  output logic [15:0]        corner_cnt,
  output logic               err
);

  localparam int CW      = $clog2(OFIFO_DEPTH) + 1;
  localparam int FLUSH_N = flush_pix(COL_NUM, NMS_SIZE);
  localparam logic [CW-1:0]      MAX_FILL   = CW'(OFIFO_DEPTH - NMS_LAT - 1);
  localparam logic [COORD_W-1:0] X_LAST     = COORD_W'(COL_NUM - 1);
  localparam logic [COORD_W-1:0] Y_LAST     = COORD_W'(ROW_NUM - 1);
  localparam logic [COORD_W-1:0] Y_LIMIT    = COORD_W'(ROW_NUM);
  localparam logic [15:0]        FLUSH_LAST = 16'(FLUSH_N - 1);
  localparam logic [7:0]         DRAIN_LAST = 8'(NMS_LAT - 1);

  state_t             state;
  logic [COORD_W-1:0] x;
  logic [COORD_W-1:0] y;
  logic [15:0]        flush_cnt;
  logic [7:0]         drain_cnt;
  logic               ce_q;
  logic [CW-1:0]      fifo_count;
  logic               fifo_full;
  logic               fifo_empty;
  corner_t            fifo_head;
  corner_t            cap_corner;
  logic               space_ok;
  logic               advance;
  logic               flush_step;
  logic               drain_step;
  logic               at_eol;
  logic               cap;
  logic               pop;

  // NMS may only step while the FIFO can absorb every result still inside
  // the NMS pipeline plus the one being captured right now.
  assign space_ok   = (fifo_count <= MAX_FILL);
  assign pix_rdy    = (state == RUN) && space_ok;
  assign advance    = pix_vld && pix_rdy;
  assign flush_step = (state == FLUSH) && space_ok;
  assign drain_step = (state == DRAIN) && space_ok;
  assign at_eol     = (x == X_LAST);

  assign nms_xy_vld   = advance || flush_step;
  assign nms_ce       = nms_xy_vld || drain_step;
  assign nms_eol      = nms_xy_vld && at_eol;
  assign nms_x        = x;
  assign nms_y        = y;
  assign nms_score    = (state == RUN) ? pix_score : '0;
  assign nms_iscorner = (state == RUN) && pix_corner;

  assign busy       = (state != IDLE);
  assign frame_done = (state == DONE);

  // corner_out is only fresh on the cycle after a ce step; flush-row
  // results (y beyond the frame) are discarded.
  assign cap          = ce_q && nms_corner_out && (nms_y_out < Y_LIMIT);
  assign pop          = !fifo_empty && crn_rdy;
  assign cap_corner.x = nms_x_out;
  assign cap_corner.y = nms_y_out;

  assign crn_vld = !fifo_empty;
  assign crn_x   = fifo_empty ? '0 : fifo_head.x;
  assign crn_y   = fifo_empty ? '0 : fifo_head.y;

  nms_corner_fifo #(
    .WIDTH (2 * COORD_W),
    .DEPTH (OFIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (cap),
    .din   (cap_corner),
    .pop   (pop),
    .head  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Frame FSM plus coordinate counters, capture bookkeeping and the sticky
  // error. The raster position keeps running through the flush pixels so
  // NMS sees rows beyond the frame; IDLE clears are placed last so a new
  // frame always starts from zero.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      x          <= '0;
      y          <= '0;
      flush_cnt  <= '0;
      drain_cnt  <= '0;
      ce_q       <= 1'b0;
      corner_cnt <= '0;
      err        <= 1'b0;
    end else begin
      ce_q <= nms_ce;

      if ((frame_start && state != IDLE) || (cap && fifo_full && !pop))
        err <= 1'b1;

      if (cap && corner_cnt != 16'hFFFF)
        corner_cnt <= corner_cnt + 16'd1;

      if (nms_xy_vld) begin
        if (at_eol) begin
          x <= '0;
          y <= y + COORD_W'(1);
        end else begin
          x <= x + COORD_W'(1);
        end
      end

      unique case (state)
        IDLE: begin
          if (frame_start) begin
            state      <= RUN;
            x          <= '0;
            y          <= '0;
            corner_cnt <= '0;
          end
        end
        RUN: begin
          if (advance && at_eol && y == Y_LAST) begin
            state     <= (FLUSH_N == 0) ? DRAIN : FLUSH;
            flush_cnt <= '0;
            drain_cnt <= '0;
          end
        end
        FLUSH: begin
          if (flush_step) begin
            flush_cnt <= flush_cnt + 16'd1;
            if (flush_cnt == FLUSH_LAST) begin
              state     <= DRAIN;
              drain_cnt <= '0;
            end
          end
        end
        DRAIN: begin
          if (drain_step) begin
            drain_cnt <= drain_cnt + 8'd1;
            if (drain_cnt == DRAIN_LAST) state <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
